toycpu_core_exec: RTL and testbench
===================================

Name: toycpu_core_exec

Overview:
- Execution core of the 16-bit toy CPU: instruction decoder, 16x16 register file, ALU with registered carry/zero flags, write-back mux and memory-address mux in one block.
- Sits between the processor top's instruction memory, PC register and data memory.
- The top owns the PC: 01 = load instrData, 10 = load regSrcData, other = PC+1.

Parameters:
- NREGS, 16, number of registers (index width fixed at 4 bits).
- DW, 16, datapath width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- instruction  in  16  current instruction word.
- memRData  in  16  combinational data-memory read data at memAddr.
- nextPCSel  out  2  00 = PC+1, 01 = instrData, 10 = regSrcData.
- instrData  out  16  decoded immediate / jump target.
- regSrcData  out  16  source-register value; also store data.
- memAddr  out  16  data-memory address.
- memWE  out  1  data-memory write strobe; top writes on the clk edge.
- cFlag  out  1  registered carry flag.
- zFlag  out  1  registered zero flag.

Interface notes:
- reset rst, asynchronous, active-high; clock clk.
- Everything is combinational from instruction except register contents and flags.

Behaviour:
- Fields: op = [15:12], d = [11:8], s = [7:4], imm8 = [7:0], abs12 = [11:0], cc = [11:10], abs10 = [9:0].
- Opcodes (R = register file; C and Z updated only where stated):
  - 0 NOP: no writes.
  - 1 ADD: R[d] = R[d]+R[s]; C = carry out of bit 15.
  - 2 SUB: R[d] = R[d]-R[s]; C = 1 when R[d] < R[s] unsigned.
  - 3 AND, 4 OR, 5 XOR: R[d] = R[d] op R[s]; C = 0.
  - 6 NOT: R[d] = ~R[s]; C = 0.
  - 7 SHL: R[d] = R[s]<<1; C = R[s][15].
  - 8 SHR (logical): R[d] = R[s]>>1; C = R[s][0].
  - 9 MOV: R[d] = R[s]; flags unchanged.
  - A LDI: R[d] = zero-extended imm8.
  - B LD: memAddr = R[s]; R[d] = memRData.
  - C ST: memAddr = R[d]; memWE = 1; write data = regSrcData.
  - D JMP: nextPCSel = 01; instrData = zero-extended abs12.
  - E JR: nextPCSel = 10; jump target = R[s].
  - F Bcc: instrData = zero-extended abs10. cc: 00 = Z, 01 = !Z, 10 = C, 11 = !C. Condition true -> nextPCSel = 01, else 00.
- Flags:
  - Ops 1-8 set Z = (result == 0) and C as listed above.
  - Both flags are captured on the clk rising edge, so a branch tests the flags left by the most recent earlier op 1-8.
  - All other opcodes hold both flags.
- Register write enable: ops 1-B.
  - Write-back mux order: immediate (A), then memRData (B), then ALU result.
  - Write to R[d] occurs on the rising edge.
- Register reads:
  - Two asynchronous read ports (d and s).
  - When reading and writing the same register, the read returns the old value; the new value is visible after the edge.
- Default outputs:
  - instrData = zero-extended imm8 for ops 0-C.
  - memAddr = instrData unless op B or C.
  - memWE = 0 except op C; nextPCSel = 00 except ops D, E and taken F.
- Arithmetic: all results are modulo 2^16, no saturation. R0 is an ordinary register.
- Reset: asynchronous; all registers = 0, C = 0, Z = 0 immediately, including mid-instruction. No write occurs while rst is high.

Optional Feature:
- TOYCPU_DEBUG_EN defined: extra outputs reg0, reg1, reg2, reg3 (16 bits each), continuous views of R0-R3.
- Undefined: these ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-run -> every register reads 0 and C = Z = 0 while rst is high.
- LDI/ADD: LDI R1,0xFF; LDI R2,0x01; ADD R1,R2 -> R1 = 0x0100, C = 0, Z = 0. Then LDI R3,0x00, SUB R3,R2 -> R3 = 0xFFFF, C = 1.
- Zero flag and branch: LDI R4,5; SUB R4,R4 -> Z = 1. Then instruction 0xF012 -> nextPCSel = 01, instrData = 0x0012. Then 0xF412 (JNZ) -> nextPCSel = 00.
- Shift: R5 = 0x8001. SHL R6,R5 -> R6 = 0x0002, C = 1. SHR R7,R5 -> R7 = 0x4000, C = 1.
- Memory: R1 = 0x0010, R2 = 0xBEEF, ST R1,R2 -> memWE = 1, memAddr = 0x0010, regSrcData = 0xBEEF. LD R3,R1 with memRData = 0xBEEF -> R3 = 0xBEEF after the edge.
- Jumps: 0xD123 -> nextPCSel = 01, instrData = 0x0123. JR R2 with R2 = 0x0040 -> nextPCSel = 10, regSrcData = 0x0040. MOV after ADD leaves the flags unchanged.

Source files
------------

// File: rtl/toycpu_core_exec.sv
// Execution core of the 16-bit toy CPU: decoder, 16x16 register file, ALU, carry/zero flags and address mux.
// Define TOYCPU_DEBUG_EN to add the reg0..reg3 observation ports.
module toycpu_core_exec #(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instruction,
    input  logic [DW-1:0] memRData,
    output logic [1:0]    nextPCSel,
    output logic [DW-1:0] instrData,
    output logic [DW-1:0] regSrcData,
    output logic [DW-1:0] memAddr,
    output logic          memWE,
    output logic          cFlag,
`ifdef TOYCPU_DEBUG_EN
    output logic [DW-1:0] reg0,
    output logic [DW-1:0] reg1,
    output logic [DW-1:0] reg2,
    output logic [DW-1:0] reg3,
`endif
    output logic          zFlag
);

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9, OP_LDI = 4'hA, OP_LD  = 4'hB, OP_ST  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD, OP_JR  = 4'hE, OP_BCC = 4'hF;

    logic [3:0]    op, rd_idx, rs_idx;
    logic [1:0]    cc;
    logic [DW-1:0] rd_val, rs_val;
    logic [DW-1:0] alu_res, wb_data;
    logic          alu_c, flag_we, reg_we, br_take;
    logic          c_q, c_d, z_q, z_d;
    logic [DW-1:0] regs_q [NREGS];

    assign op     = instruction[15:12];
    assign rd_idx = instruction[11:8];
    assign rs_idx = instruction[7:4];
    assign cc     = instruction[11:10];

    // Asynchronous read ports return the pre-edge value when the same register is being written.
    assign rd_val = regs_q[rd_idx];
    assign rs_val = regs_q[rs_idx];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
            OP_SUB: begin
                alu_res = rd_val - rs_val;
                alu_c   = (rd_val < rs_val);
            end
            OP_AND: alu_res = rd_val & rs_val;
            OP_OR:  alu_res = rd_val | rs_val;
            OP_XOR: alu_res = rd_val ^ rs_val;
            OP_NOT: alu_res = ~rs_val;
            OP_SHL: begin
                alu_res = rs_val << 1;
                alu_c   = rs_val[DW-1];
            end
            OP_SHR: begin
                alu_res = rs_val >> 1;
                alu_c   = rs_val[0];
            end
            OP_MOV: alu_res = rs_val;
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    assign flag_we = (op >= OP_ADD) && (op <= OP_SHR);
    assign reg_we  = (op >= OP_ADD) && (op <= OP_LD);
    assign c_d     = flag_we ? alu_c : c_q;
    assign z_d     = flag_we ? (alu_res == '0) : z_q;

    always_comb begin
        if (op == OP_LDI)     wb_data = {{(DW-8){1'b0}}, instruction[7:0]};
        else if (op == OP_LD) wb_data = memRData;
        else                  wb_data = alu_res;
    end

    // Branch conditions test the flags left by earlier instructions, never the current one.
    always_comb begin
        case (cc)
            2'b00:   br_take = z_q;
            2'b01:   br_take = ~z_q;
            2'b10:   br_take = c_q;
            default: br_take = ~c_q;
        endcase
    end

    always_comb begin
        nextPCSel = 2'b00;
        instrData = {{(DW-8){1'b0}}, instruction[7:0]};
        memAddr   = instrData;
        memWE     = 1'b0;
        case (op)
            OP_LD:  memAddr = rs_val;
            OP_ST: begin
                memAddr = rd_val;
                memWE   = 1'b1;
            end
            OP_JMP: begin
                instrData = {{(DW-12){1'b0}}, instruction[11:0]};
                memAddr   = instrData;
                nextPCSel = 2'b01;
            end
            OP_JR:  nextPCSel = 2'b10;
            OP_BCC: begin
                instrData = {{(DW-10){1'b0}}, instruction[9:0]};
                memAddr   = instrData;
                nextPCSel = br_take ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    assign regSrcData = rs_val;
    assign cFlag      = c_q;
    assign zFlag      = z_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            if (reg_we) regs_q[rd_idx] <= wb_data;
        end
    end

`ifdef TOYCPU_DEBUG_EN
    assign reg0 = regs_q[0];
    assign reg1 = regs_q[1];
    assign reg2 = regs_q[2];
    assign reg3 = regs_q[3];
`endif

endmodule

// File: tb/tb_toycpu_core_exec.sv
// Directed bench for toycpu_core_exec: a table of instructions with hand-computed outputs plus a mid-run reset sequence.
module tb_toycpu_core_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic [15:0] memRData = 16'h0000;
    logic [1:0]  nextPCSel;
    logic [15:0] instrData, regSrcData, memAddr;
    logic        memWE, cFlag, zFlag;
`ifdef TOYCPU_DEBUG_EN
    logic [15:0] reg0, reg1, reg2, reg3;
`endif

    int checks = 0;
    int errors = 0;

    toycpu_core_exec dut (
        .clk(clk), .rst(rst), .instruction(instruction), .memRData(memRData),
        .nextPCSel(nextPCSel), .instrData(instrData), .regSrcData(regSrcData),
        .memAddr(memAddr), .memWE(memWE), .cFlag(cFlag),
`ifdef TOYCPU_DEBUG_EN
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
`endif
        .zFlag(zFlag)
    );

    always #5 clk = ~clk;

    // Each record: instruction, memory read data, then the combinational outputs and the
    // flags expected just before this instruction's clock edge.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] mrd;
        logic [1:0]  sel;
        logic [15:0] idata;
        logic [15:0] src;
        logic [15:0] addr;
        logic        we;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] instr, input logic [15:0] mrd, input logic [1:0] sel,
                       input logic [15:0] idata, input logic [15:0] src, input logic [15:0] addr,
                       input logic we, input logic c, input logic z);
        vq.push_back('{instr, mrd, sel, idata, src, addr, we, c, z});
    endtask

    initial begin
        //   instr     mrd      sel  idata     src       addr      we c  z
        add(16'hA1FF, 16'h0000, 2'd0, 16'h00FF, 16'h0000, 16'h00FF, 0, 0, 0); // LDI R1,FF
        add(16'hA201, 16'h0000, 2'd0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0); // LDI R2,1
        add(16'h1120, 16'h0000, 2'd0, 16'h0020, 16'h0001, 16'h0020, 0, 0, 0); // ADD R1,R2
        add(16'h0010, 16'h0000, 2'd0, 16'h0010, 16'h0100, 16'h0010, 0, 0, 0); // NOP view R1
        add(16'hA300, 16'h0000, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0); // LDI R3,0
        add(16'h2320, 16'h0000, 2'd0, 16'h0020, 16'h0001, 16'h0020, 0, 0, 0); // SUB R3,R2
        add(16'h0030, 16'h0000, 2'd0, 16'h0030, 16'hFFFF, 16'h0030, 0, 1, 0); // NOP view R3
        add(16'hA405, 16'h0000, 2'd0, 16'h0005, 16'h0000, 16'h0005, 0, 1, 0); // LDI R4,5
        add(16'h2440, 16'h0000, 2'd0, 16'h0040, 16'h0005, 16'h0040, 0, 1, 0); // SUB R4,R4
        add(16'hF012, 16'h0000, 2'd1, 16'h0012, 16'h0100, 16'h0012, 0, 0, 1); // BZ taken
        add(16'hF412, 16'h0000, 2'd0, 16'h0012, 16'h0100, 16'h0012, 0, 0, 1); // BNZ not taken
        add(16'hFC12, 16'h0000, 2'd1, 16'h0012, 16'h0100, 16'h0012, 0, 0, 1); // BNC taken
        add(16'hB500, 16'h8001, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1); // LD R5,[R0]
        add(16'h7650, 16'h0000, 2'd0, 16'h0050, 16'h8001, 16'h0050, 0, 0, 1); // SHL R6,R5
        add(16'h0060, 16'h0000, 2'd0, 16'h0060, 16'h0002, 16'h0060, 0, 1, 0); // NOP view R6
        add(16'h8750, 16'h0000, 2'd0, 16'h0050, 16'h8001, 16'h0050, 0, 1, 0); // SHR R7,R5
        add(16'h0070, 16'h0000, 2'd0, 16'h0070, 16'h4000, 16'h0070, 0, 1, 0); // NOP view R7
        add(16'hA110, 16'h0000, 2'd0, 16'h0010, 16'h0100, 16'h0010, 0, 1, 0); // LDI R1,10 reads old R1
        add(16'hB200, 16'hBEEF, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0); // LD R2,[R0]
        add(16'hC120, 16'h0000, 2'd0, 16'h0020, 16'hBEEF, 16'h0010, 1, 1, 0); // ST [R1],R2
        add(16'hB310, 16'hBEEF, 2'd0, 16'h0010, 16'h0010, 16'h0010, 0, 1, 0); // LD R3,[R1]
        add(16'h0030, 16'h0000, 2'd0, 16'h0030, 16'hBEEF, 16'h0030, 0, 1, 0); // NOP view R3
        add(16'hD123, 16'h0000, 2'd1, 16'h0123, 16'hBEEF, 16'h0123, 0, 1, 0); // JMP 123
        add(16'hA240, 16'h0000, 2'd0, 16'h0040, 16'h0000, 16'h0040, 0, 1, 0); // LDI R2,40
        add(16'hE020, 16'h0000, 2'd2, 16'h0020, 16'h0040, 16'h0020, 0, 1, 0); // JR R2
        add(16'h6A00, 16'h0000, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0); // NOT R10,R0
        add(16'hAB01, 16'h0000, 2'd0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0); // LDI R11,1
        add(16'h1AB0, 16'h0000, 2'd0, 16'h00B0, 16'h0001, 16'h00B0, 0, 0, 0); // ADD R10,R11 wraps
        add(16'h9C20, 16'h0000, 2'd0, 16'h0020, 16'h0040, 16'h0020, 0, 1, 1); // MOV R12,R2
        add(16'h00C0, 16'h0000, 2'd0, 16'h00C0, 16'h0040, 16'h00C0, 0, 1, 1); // flags held by MOV
        add(16'h3C30, 16'h0000, 2'd0, 16'h0030, 16'hBEEF, 16'h0030, 0, 1, 1); // AND R12,R3
        add(16'h5CC0, 16'h0000, 2'd0, 16'h00C0, 16'h0040, 16'h00C0, 0, 0, 0); // XOR R12,R12
        add(16'h4C20, 16'h0000, 2'd0, 16'h0020, 16'h0040, 16'h0020, 0, 0, 1); // OR R12,R2
        add(16'h00C0, 16'h0000, 2'd0, 16'h00C0, 16'h0040, 16'h00C0, 0, 0, 0); // NOP view R12
        add(16'h2020, 16'h0000, 2'd0, 16'h0020, 16'h0040, 16'h0020, 0, 0, 0); // SUB R0,R2
        add(16'h0000, 16'h0000, 2'd0, 16'h0000, 16'hFFC0, 16'h0000, 0, 1, 0); // NOP view R0

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_c", {15'b0, cFlag}, 16'h0000);
        chk("rst_z", {15'b0, zFlag}, 16'h0000);
        chk("rst_r0", regSrcData, 16'h0000);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            instruction = vq[i].instr;
            memRData    = vq[i].mrd;
            #1;
            chk($sformatf("v%0d_sel", i), {14'b0, nextPCSel}, {14'b0, vq[i].sel});
            chk($sformatf("v%0d_idata", i), instrData, vq[i].idata);
            chk($sformatf("v%0d_src", i), regSrcData, vq[i].src);
            chk($sformatf("v%0d_addr", i), memAddr, vq[i].addr);
            chk($sformatf("v%0d_we", i), {15'b0, memWE}, {15'b0, vq[i].we});
            chk($sformatf("v%0d_c", i), {15'b0, cFlag}, {15'b0, vq[i].c});
            chk($sformatf("v%0d_z", i), {15'b0, zFlag}, {15'b0, vq[i].z});
        end

        // Mid-run asynchronous reset with a write pending: clears at once and blocks the write
        @(negedge clk);
        instruction = 16'hA155;
        memRData    = 16'h0000;
        #1;
        chk("pre_rst_r5", regSrcData, 16'h8001);
        chk("pre_rst_c", {15'b0, cFlag}, 16'h0001);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_c", {15'b0, cFlag}, 16'h0000);
        chk("async_rst_z", {15'b0, zFlag}, 16'h0000);
        chk("async_rst_r5", regSrcData, 16'h0000);
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            instruction = {8'h00, 4'(i), 4'h0};
            #1;
            chk($sformatf("rst_r%0d", i), regSrcData, 16'h0000);
        end
        chk("rst_hold_c", {15'b0, cFlag}, 16'h0000);
        chk("rst_hold_z", {15'b0, zFlag}, 16'h0000);

        // Writes resume after release
        @(negedge clk);
        rst = 1'b0;
        instruction = 16'hA155;
        @(negedge clk);
        instruction = 16'h0010;
        #1;
        chk("post_rst_r1", regSrcData, 16'h0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
